// File: rtl/debounce_step_gen.sv
// Pushbutton conditioner: two-flop synchronizer, debounce filter and a
// press / hold / auto-repeat FSM producing single-cycle step strobes.
module debounce_step_gen #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned REPEAT_CYCLES = 16,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic step_pulse,
  output logic btn_level,
  output logic repeating
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             sync_0_r;
  logic             sync_1_r;
  logic             btn_level_r;
  logic [CNT_W-1:0] db_cnt_r;
  logic             accept_rise_s;
  logic             accept_fall_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] rep_cnt_nxt_s;
  logic             pulse_nxt_s;
  logic             step_pulse_r;
  logic             repeating_r;

  // A level change is accepted on the edge that completes STABLE_CYCLES differing samples.
  assign accept_rise_s = (db_cnt_r == STABLE_LAST) && sync_1_r && !btn_level_r;
  assign accept_fall_s = (db_cnt_r == STABLE_LAST) && !sync_1_r && btn_level_r;

  // Synchronizer and debounce filter.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0_r    <= 1'b0;
      sync_1_r    <= 1'b0;
      btn_level_r <= 1'b0;
      db_cnt_r    <= CNT_ZERO;
    end else begin
      sync_0_r <= btn_in;
      sync_1_r <= sync_0_r;
      if (sync_1_r == btn_level_r) begin
        db_cnt_r <= CNT_ZERO;
      end else if (db_cnt_r == STABLE_LAST) begin
        db_cnt_r    <= CNT_ZERO;
        btn_level_r <= ~btn_level_r;
      end else begin
        db_cnt_r <= db_cnt_r + CNT_ONE;
      end
    end
  end

  // Press / hold / repeat next-state and strobe decode; release always wins.
  always_comb begin
    state_nxt_s   = state_r;
    rep_cnt_nxt_s = rep_cnt_r;
    pulse_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        rep_cnt_nxt_s = CNT_ZERO;
        if (accept_rise_s) begin
          state_nxt_s = ST_HOLD;
          pulse_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (accept_fall_s) begin
          state_nxt_s   = ST_IDLE;
          rep_cnt_nxt_s = CNT_ZERO;
        end else if (rep_cnt_r == HOLD_LAST) begin
          if (REPEAT_EN) begin
            state_nxt_s   = ST_REPEAT;
            rep_cnt_nxt_s = CNT_ZERO;
            pulse_nxt_s   = 1'b1;
          end else begin
            // Single-shot mode parks here until release.
            rep_cnt_nxt_s = rep_cnt_r;
          end
        end else begin
          rep_cnt_nxt_s = rep_cnt_r + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (accept_fall_s) begin
          state_nxt_s   = ST_IDLE;
          rep_cnt_nxt_s = CNT_ZERO;
        end else if (rep_cnt_r == REPEAT_LAST) begin
          rep_cnt_nxt_s = CNT_ZERO;
          pulse_nxt_s   = 1'b1;
        end else begin
          rep_cnt_nxt_s = rep_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        rep_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // FSM state, shared hold/repeat counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      rep_cnt_r    <= CNT_ZERO;
      step_pulse_r <= 1'b0;
      repeating_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      rep_cnt_r    <= rep_cnt_nxt_s;
      step_pulse_r <= pulse_nxt_s;
      repeating_r  <= (state_nxt_s == ST_REPEAT);
    end
  end

  assign step_pulse = step_pulse_r;
  assign btn_level  = btn_level_r;
  assign repeating  = repeating_r;

endmodule

// File: tb/tb_debounce_step_gen.sv
// Bench for debounce_step_gen: auto-repeat and single-shot instances share
// stimulus and are compared each cycle against a timeline-based model.
module tb_debounce_step_gen;

  localparam int S = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clock;
  logic reset;
  logic btn_in;
  logic step_pulse, btn_level, repeating;
  logic step_pulse_nr, btn_level_nr, repeating_nr;

  int checks = 0;
  int fails  = 0;

  debounce_step_gen #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                      .REPEAT_EN(1'b1), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .step_pulse(step_pulse), .btn_level(btn_level), .repeating(repeating));

  debounce_step_gen #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                      .REPEAT_EN(1'b0), .CNT_W(4)) dut_nr (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .step_pulse(step_pulse_nr), .btn_level(btn_level_nr), .repeating(repeating_nr));

  always #5 clock = ~clock;

  wire [5:0] obs = {step_pulse, btn_level, repeating, step_pulse_nr, btn_level_nr, repeating_nr};

  // Reference model: a two-sample delay line, a run length of samples that
  // disagree with the accepted level, and a per-instance timeline of when
  // the next repeat strobe is due.
  int cyc = 0;
  bit pipe[$];
  bit m_level;
  int run_len;
  bit m_active[2];
  bit m_rep[2];
  bit m_pulse[2];
  int m_next[2];
  bit en_of[2] = '{1'b1, 1'b0};

  function automatic logic [5:0] expv();
    return {m_pulse[0], m_level, m_rep[0], m_pulse[1], m_level, m_rep[1]};
  endfunction

  task automatic advance(input bit b, input bit r);
    bit cur, rise, fall;
    @(negedge clock);
    btn_in = b;
    reset  = r;
    @(posedge clock);
    cyc++;
    if (r) begin
      pipe    = {1'b0, 1'b0};
      m_level = 1'b0;
      run_len = 0;
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0; m_rep[i] = 1'b0; m_pulse[i] = 1'b0;
      end
    end else begin
      cur = pipe.pop_front();
      pipe.push_back(b);
      rise = 1'b0; fall = 1'b0;
      if (cur == m_level) run_len = 0;
      else begin
        run_len++;
        if (run_len == S) begin
          m_level = cur; run_len = 0; rise = cur; fall = !cur;
        end
      end
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 1'b0;
        if (fall) begin
          m_active[i] = 1'b0; m_rep[i] = 1'b0;
        end else if (rise) begin
          m_pulse[i] = 1'b1; m_active[i] = 1'b1; m_rep[i] = 1'b0; m_next[i] = cyc + H;
        end else if (m_active[i] && en_of[i] && cyc == m_next[i]) begin
          m_pulse[i] = 1'b1; m_rep[i] = 1'b1; m_next[i] = cyc + R;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      advance(i[0], 1'b1);
      checks++;
      if (obs !== 6'b000000) begin
        fails++; $display("FAIL reset_outputs cyc=%0d got=%b want=000000", cyc, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    int e0, npulse, pofs, fofs;
    for (int i = 0; i < 3; i++) begin
      advance(1'b0, 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL press_idle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
    end
    e0 = cyc + 1; npulse = 0; pofs = -1; fofs = -1;
    for (int i = 0; i < 22; i++) begin
      advance(i < 8, 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL press_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      if (step_pulse) begin npulse++; pofs = cyc - e0; end
      if (i >= 8 && !btn_level && fofs < 0) fofs = cyc - e0;
    end
    checks++;
    if (pofs != 5) begin fails++; $display("FAIL press_latency got=%0d want=5", pofs); end
    checks++;
    if (npulse != 1) begin fails++; $display("FAIL press_count got=%0d want=1", npulse); end
    checks++;
    if (fofs != 13) begin fails++; $display("FAIL release_latency got=%0d want=13", fofs); end
  endtask

  task automatic test_bounce();
    int npulse, seen_level;
    npulse = 0; seen_level = 0;
    for (int i = 0; i < 46; i++) begin
      advance((i < 40) && ((i % 4) != 3), 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL bounce_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      if (step_pulse || step_pulse_nr) npulse++;
      if (btn_level) seen_level++;
    end
    checks++;
    if (npulse != 0) begin fails++; $display("FAIL bounce_pulses got=%0d want=0", npulse); end
    checks++;
    if (seen_level != 0) begin fails++; $display("FAIL bounce_level got=%0d want=0", seen_level); end
  endtask

  task automatic test_hold_repeat();
    int e0, rep_on, rep_off, lvl_off;
    int got[$];
    int want[$];
    e0 = cyc + 1; rep_on = -1; rep_off = -1; lvl_off = -1;
    want.push_back(5);
    for (int t = 15; t < 45; t += R) want.push_back(t);
    for (int i = 0; i < 52; i++) begin
      advance(i < 40, 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL hold_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      if (step_pulse) got.push_back(cyc - e0);
      if (repeating && rep_on < 0) rep_on = cyc - e0;
      if (rep_on >= 0 && !repeating && rep_off < 0) rep_off = cyc - e0;
      if (i >= 40 && !btn_level && lvl_off < 0) lvl_off = cyc - e0;
    end
    checks++;
    if (got != want) begin
      fails++; $display("FAIL hold_pulse_times got_n=%0d want_n=%0d", got.size(), want.size());
    end
    checks++;
    if (rep_on != 15) begin fails++; $display("FAIL repeating_rise got=%0d want=15", rep_on); end
    checks++;
    if (rep_off != 45 || lvl_off != 45) begin
      fails++; $display("FAIL repeating_fall got=%0d level_fall=%0d want=45", rep_off, lvl_off);
    end
  endtask

  task automatic test_collision();
    int k, len, e0, coll;
    k = $urandom_range(1, 4);
    len = 10 + R * k;
    e0 = cyc + 1;
    coll = len + S + 1;
    for (int i = 0; i < len + 12; i++) begin
      advance(i < len, 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL collide_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      if (cyc - e0 == coll) begin
        checks++;
        if ({step_pulse, repeating, btn_level} !== 3'b000) begin
          fails++; $display("FAIL collide_edge got=%b want=000", {step_pulse, repeating, btn_level});
        end
      end
    end
  endtask

  task automatic test_norep();
    int npulse;
    npulse = 0;
    for (int i = 0; i < 52; i++) begin
      advance(i < 40, 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL norep_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      if (step_pulse_nr) npulse++;
    end
    checks++;
    if (npulse != 1) begin fails++; $display("FAIL norep_count got=%0d want=1", npulse); end
  endtask

  task automatic test_reset_mid_hold();
    int r0, pofs;
    for (int i = 0; i < 20; i++) advance(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      advance(1'b1, 1'b1);
      checks++;
      if (obs !== 6'b000000) begin fails++; $display("FAIL midhold_reset cyc=%0d got=%b want=000000", cyc, obs); end
    end
    r0 = cyc + 1; pofs = -1;
    for (int i = 0; i < 12; i++) begin
      advance(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin fails++; $display("FAIL midhold_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      if (step_pulse && pofs < 0) pofs = cyc - r0;
    end
    checks++;
    if (pofs != 5) begin fails++; $display("FAIL midhold_latency got=%0d want=5", pofs); end
    for (int i = 0; i < 10; i++) advance(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit lvl;
    int n;
    for (int blk = 0; blk < 60; blk++) begin
      lvl = $urandom_range(0, 1);
      n = (blk % 3 == 0) ? $urandom_range(1, 4) : $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        advance(lvl, ($urandom_range(0, 99) == 0));
        checks++;
        if (obs !== expv()) begin fails++; $display("FAIL random_cycle cyc=%0d got=%b want=%b", cyc, obs, expv()); end
      end
    end
  endtask

  initial begin
    clock  = 1'b0;
    reset  = 1'b1;
    btn_in = 1'b0;
    pipe   = {1'b0, 1'b0};
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_collision();
    test_norep();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
